// File: rtl/tx_framer.sv
// tx_framer: parallel word to asynchronous serial frame with optional parity and one or two stop bits.
module tx_framer #(
  parameter  int DATA_W    = 8,
  parameter  int LSB_FIRST = 0,
  localparam int FRAME_W   = DATA_W + 4
) (
  input  logic               i_Pclk,
  input  logic               i_Rst,
  input  logic               i_Tick,
  input  logic [2:0]         i_Parity,
  input  logic               i_Stop2,
  input  logic               i_Valid,
  input  logic [DATA_W-1:0]  i_Data,
  output logic               o_Ready,
  output logic               o_Tx,
  output logic               o_Busy,
  output logic [FRAME_W-1:0] o_Frame,
  output logic               o_Done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP1  = 3'd5,
    STOP2  = 3'd6
  } state_t;

  state_t              state_r, state_nxt;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt;
  logic [DATA_W-1:0]   sh_r, sh_nxt;
  logic [DATA_W-1:0]   ord_data;
  logic [FRAME_W-1:0]  frame_r;
  logic                tx_r, tx_nxt;
  logic                done_r, done_nxt;
  logic                busy_r, ready_r;
  logic                par_en_r, stop2_r;
  logic                cap_par, cap_par_en;
  logic                accept;

  assign accept = i_Valid & ready_r;

  // Data word rearranged into transmit order; this is both the frame field and the shift source.
  always_comb begin
    if (LSB_FIRST != 0) begin
      ord_data = {<<{i_Data}};
    end else begin
      ord_data = i_Data;
    end
  end

  // Parity slot value and enable from the offered word; an unused slot reads 1.
  always_comb begin
    cap_par    = 1'b1;
    cap_par_en = 1'b0;
    case (i_Parity)
      3'b001:  begin cap_par = ^i_Data;  cap_par_en = 1'b1; end
      3'b010:  begin cap_par = ~^i_Data; cap_par_en = 1'b1; end
      3'b011:  begin cap_par = 1'b1;     cap_par_en = 1'b1; end
      3'b100:  begin cap_par = 1'b0;     cap_par_en = 1'b1; end
      default: begin cap_par = 1'b1;     cap_par_en = 1'b0; end
    endcase
  end

  // Next state and next line value; the line register only moves on ticks.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    sh_nxt    = sh_r;
    tx_nxt    = tx_r;
    done_nxt  = 1'b0;
    case (state_r)
      IDLE: begin
        tx_nxt  = 1'b1;
        cnt_nxt = '0;
        if (accept) begin
          state_nxt = SYNC;
          sh_nxt    = ord_data;
        end
      end
      SYNC: begin
        tx_nxt = 1'b1;
        if (i_Tick) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (i_Tick) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          tx_nxt    = sh_r[DATA_W-1];
          sh_nxt    = {sh_r[DATA_W-2:0], 1'b0};
        end
      end
      DATA: begin
        if (i_Tick) begin
          if (cnt_r == LAST_BIT) begin
            if (par_en_r) begin
              state_nxt = PARITY;
              tx_nxt    = frame_r[2];
            end else begin
              state_nxt = STOP1;
              tx_nxt    = 1'b1;
            end
          end else begin
            cnt_nxt = cnt_r + CNT_W'(1);
            tx_nxt  = sh_r[DATA_W-1];
            sh_nxt  = {sh_r[DATA_W-2:0], 1'b0};
          end
        end
      end
      PARITY: begin
        if (i_Tick) begin
          state_nxt = STOP1;
          tx_nxt    = 1'b1;
        end
      end
      STOP1: begin
        tx_nxt = 1'b1;
        if (i_Tick) begin
          if (stop2_r) begin
            state_nxt = STOP2;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      STOP2: begin
        tx_nxt = 1'b1;
        if (i_Tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // State, line and handshake registers; ready needs a full IDLE cycle, so it lags Done and reset release by one clock.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      sh_r     <= '0;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
      frame_r  <= '1;
      par_en_r <= 1'b0;
      stop2_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      sh_r    <= sh_nxt;
      tx_r    <= tx_nxt;
      done_r  <= done_nxt;
      busy_r  <= (state_nxt != IDLE);
      ready_r <= (state_r == IDLE) && (state_nxt == IDLE);
      if (accept) begin
        frame_r  <= {1'b0, ord_data, cap_par, 1'b1, 1'b1};
        par_en_r <= cap_par_en;
        stop2_r  <= i_Stop2;
      end
    end
  end

  assign o_Ready = ready_r;
  assign o_Tx    = tx_r;
  assign o_Busy  = busy_r;
  assign o_Frame = frame_r;
  assign o_Done  = done_r;

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: three framer variants driven in parallel against a bit-queue reference model.
module tb_tx_framer;

  logic        clk = 1'b0;
  logic        i_Rst, i_Tick, i_Stop2, i_Valid;
  logic [2:0]  i_Parity;
  logic [7:0]  i_Data;
  logic [2:0]  tx_w, busy_w, done_w, ready_w;
  logic [11:0] fr0, fr1;
  logic [10:0] fr2;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int          div_cnt = 0;

  logic        m_tx[3], m_busy[3], m_ready[3], m_done[3];
  int          m_pos[3], m_len[3];
  logic [31:0] m_frame[3];
  bit          m_seq[3][16];

  tx_framer #(.DATA_W(8), .LSB_FIRST(0)) u_msb8 (
    .i_Pclk(clk), .i_Rst(i_Rst), .i_Tick(i_Tick), .i_Parity(i_Parity), .i_Stop2(i_Stop2),
    .i_Valid(i_Valid), .i_Data(i_Data), .o_Ready(ready_w[0]), .o_Tx(tx_w[0]),
    .o_Busy(busy_w[0]), .o_Frame(fr0), .o_Done(done_w[0]));

  tx_framer #(.DATA_W(8), .LSB_FIRST(1)) u_lsb8 (
    .i_Pclk(clk), .i_Rst(i_Rst), .i_Tick(i_Tick), .i_Parity(i_Parity), .i_Stop2(i_Stop2),
    .i_Valid(i_Valid), .i_Data(i_Data), .o_Ready(ready_w[1]), .o_Tx(tx_w[1]),
    .o_Busy(busy_w[1]), .o_Frame(fr1), .o_Done(done_w[1]));

  tx_framer #(.DATA_W(7), .LSB_FIRST(0)) u_msb7 (
    .i_Pclk(clk), .i_Rst(i_Rst), .i_Tick(i_Tick), .i_Parity(i_Parity), .i_Stop2(i_Stop2),
    .i_Valid(i_Valid), .i_Data(i_Data[6:0]), .o_Ready(ready_w[2]), .o_Tx(tx_w[2]),
    .o_Busy(busy_w[2]), .o_Frame(fr2), .o_Done(done_w[2]));

  always #5 clk = ~clk;

  function automatic int dw_of(input int k);
    return (k == 2) ? 7 : 8;
  endfunction

  function automatic bit lsb_of(input int k);
    return (k == 1);
  endfunction

  function automatic logic [31:0] dut_frame(input int k);
    case (k)
      0:       return 32'(fr0);
      1:       return 32'(fr1);
      default: return 32'(fr2);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_tx[k]    = 1'b1;
    m_busy[k]  = 1'b0;
    m_ready[k] = 1'b0;
    m_done[k]  = 1'b0;
    m_pos[k]   = -1;
    m_frame[k] = (32'd1 << (dw_of(k) + 4)) - 32'd1;
  endtask

  // Frame as a list of line bits: start, data in send order, optional parity, one or two stops.
  task automatic model_load(input int k);
    int          dw;
    int          ones;
    int          n;
    logic [8:0]  d;
    logic [31:0] f;
    bit          b, pb, pen;
    dw   = dw_of(k);
    d    = 9'(i_Data) & ((9'd1 << dw) - 9'd1);
    ones = $countones(d);
    pen  = 1'b1;
    case (i_Parity)
      3'b001:  pb = ((ones % 2) == 1);
      3'b010:  pb = ((ones % 2) == 0);
      3'b011:  pb = 1'b1;
      3'b100:  pb = 1'b0;
      default: begin pb = 1'b1; pen = 1'b0; end
    endcase
    n = 0;
    f = 32'd0;
    m_seq[k][n] = 1'b0;
    n = n + 1;
    for (int i = 0; i < dw; i++) begin
      b = lsb_of(k) ? d[i] : d[dw-1-i];
      m_seq[k][n] = b;
      n = n + 1;
      f = (f << 1) | 32'(b);
    end
    if (pen) begin
      m_seq[k][n] = pb;
      n = n + 1;
    end
    f = (f << 1) | 32'(pb);
    m_seq[k][n] = 1'b1;
    n = n + 1;
    f = (f << 1) | 32'd1;
    if (i_Stop2) begin
      m_seq[k][n] = 1'b1;
      n = n + 1;
    end
    f = (f << 1) | 32'd1;
    m_len[k]   = n;
    m_frame[k] = f;
  endtask

  task automatic model_edge(input int k);
    m_done[k] = 1'b0;
    if (i_Rst) begin
      model_reset(k);
    end else if (m_busy[k]) begin
      if (i_Tick) begin
        m_pos[k] = m_pos[k] + 1;
        if (m_pos[k] >= m_len[k]) begin
          m_done[k] = 1'b1;
          m_busy[k] = 1'b0;
          m_tx[k]   = 1'b1;
        end else begin
          m_tx[k] = m_seq[k][m_pos[k]];
        end
      end
    end else if (m_ready[k] && i_Valid) begin
      model_load(k);
      m_busy[k]  = 1'b1;
      m_ready[k] = 1'b0;
      m_pos[k]   = -1;
      m_tx[k]    = 1'b1;
    end else begin
      m_ready[k] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("tx[%0d]", k),    32'(tx_w[k]),    32'(m_tx[k]));
      check($sformatf("busy[%0d]", k),  32'(busy_w[k]),  32'(m_busy[k]));
      check($sformatf("ready[%0d]", k), 32'(ready_w[k]), 32'(m_ready[k]));
      check($sformatf("done[%0d]", k),  32'(done_w[k]),  32'(m_done[k]));
      check($sformatf("frame[%0d]", k), dut_frame(k),    m_frame[k]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    compare_all();
    div_cnt = (div_cnt + 1) % 4;
    i_Tick  = (div_cnt == 0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (ready_w !== 3'b111 && guard < 400) begin
      cyc();
      guard++;
    end
    if (guard >= 400) check("wait_idle", 32'(ready_w), 32'h7);
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] p, input logic s2);
    wait_idle();
    repeat ($urandom_range(0, 5)) cyc();
    i_Data   = d;
    i_Parity = p;
    i_Stop2  = s2;
    i_Valid  = 1'b1;
    cyc();
    i_Valid  = 1'b0;
    i_Data   = 8'($urandom);
    i_Parity = 3'($urandom);
    i_Stop2  = 1'($urandom);
  endtask

  initial begin
    int guard;
    logic [7:0] ms_data [4];
    logic [2:0] ms_par  [4];
    ms_data = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    ms_par  = '{3'b011, 3'b011, 3'b100, 3'b100};

    i_Rst = 1'b0; i_Tick = 1'b0; i_Valid = 1'b0;
    i_Parity = 3'b000; i_Stop2 = 1'b0; i_Data = 8'h00;
    #2 i_Rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    compare_all();
    repeat (3) cyc();
    i_Rst = 1'b0;
    cyc();
    check("ready_after_rst", 32'(ready_w), 32'h7);

    send(8'hA5, 3'b001, 1'b0);
    check("frame_a5_even", 32'(fr0), 32'(12'b0_10100101_0_1_1));
    wait_idle();
    send(8'h07, 3'b010, 1'b1);
    check("frame_07_odd_lsb", 32'(fr1), 32'(12'b0_11100000_0_1_1));
    wait_idle();
    send(8'h41, 3'b000, 1'b0);
    check("frame_41_w7_none", 32'(fr2), 32'(11'b0_1000001_1_1_1));
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      send(ms_data[i], ms_par[i], 1'($urandom));
      check($sformatf("mark_space_slot%0d", i), 32'(fr0[2]), (i < 2) ? 32'd1 : 32'd0);
      wait_idle();
    end
    send(8'h5A, 3'b111, 1'b0);
    check("par111_slot", 32'(fr0[2]), 32'd1);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      send(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
      wait_idle();
    end

    i_Valid = 1'b1;
    for (int i = 0; i < 160; i++) begin
      i_Data   = 8'($urandom);
      i_Parity = 3'($urandom_range(0, 7));
      i_Stop2  = 1'($urandom);
      cyc();
    end
    i_Valid = 1'b0;
    wait_idle();

    send(8'hC3, 3'b001, 1'b1);
    guard = 0;
    while (m_pos[0] != 4 && guard < 200) begin
      cyc();
      guard++;
    end
    if (guard >= 200) check("reach_bit3", 32'(m_pos[0]), 32'd4);
    #2 i_Rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    compare_all();
    check("midrst_tx", 32'(tx_w), 32'h7);
    check("midrst_busy", 32'(busy_w), 32'h0);
    repeat (2) cyc();
    i_Rst = 1'b0;
    cyc();
    check("midrst_ready_rel", 32'(ready_w), 32'h7);
    send(8'h3C, 3'b010, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter LSB_FIRST, default 0: 0 sends the MSB first, 1 sends the LSB first.
REQ-003 SHALL have parameter FRAME_W, default DATA_W+4, width of the parallel frame image; not overridable.
REQ-004 i_Pclk  in  1  single clock; all state on its rising edge.
REQ-005 i_Rst  in  1  reset, asynchronous and active-high.
REQ-006 i_Tick  in  1  bit-rate enable, one i_Pclk cycle wide; each bit lasts exactly one tick interval.
REQ-007 i_Parity  in  3  parity mode: 000 none, 001 even, 010 odd, 011 mark (1), 100 space (0); 101..111 are treated as none.
REQ-008 i_Stop2  in  1  0 selects one stop bit, 1 selects two.
REQ-009 i_Valid  in  1  data-word offer.
REQ-010 i_Data  in  DATA_W  data word.
REQ-011 o_Ready  out  1  framer can accept a word this cycle.
REQ-012 o_Tx  out  1  serial line; idles high.
REQ-013 o_Busy  out  1  a frame is in flight.
REQ-014 o_Frame  out  FRAME_W  latched frame image {start, data (in send order), parity, stop1, stop2}; unused parity or stop2 positions read 1.
REQ-015 o_Done  out  1  one-cycle pulse on the cycle the last stop bit ends.

Function
REQ-016 A word SHALL be accepted only on a cycle where i_Valid=1 and o_Ready=1, with o_Ready = 1 only in IDLE.
REQ-017 On acceptance, i_Data, i_Parity and i_Stop2 SHALL be captured; later input changes SHALL NOT affect the frame in flight.
REQ-018 Parity SHALL be computed from the captured word only:
- even: XOR of all DATA_W bits
- odd: inverted XOR of all DATA_W bits
- mark: 1
- space: 0
REQ-019 o_Frame SHALL update on the acceptance clock edge and hold until the next acceptance.
REQ-020 The state machine SHALL have the states IDLE, SYNC, START, DATA, PARITY, STOP1 and STOP2.
REQ-021 IDLE -> SYNC on acceptance; o_Busy=1 from that edge.
REQ-022 SYNC -> START on the next i_Tick, so that the start bit is tick-aligned; o_Tx stays 1 while in SYNC.
REQ-023 START drives o_Tx=0 for one tick interval, then goes to DATA.
REQ-024 DATA SHALL send DATA_W bits, one per tick interval, in the order set by LSB_FIRST, using a bit counter 0..DATA_W-1.
REQ-025 The exit from DATA SHALL go to PARITY when parity is enabled, otherwise to STOP1.
REQ-026 PARITY SHALL send the computed bit for one tick interval, then go to STOP1.
REQ-027 STOP1 SHALL drive 1 and, on the next tick, go to STOP2 if i_Stop2 was captured as 1, otherwise to IDLE.
REQ-028 STOP2 SHALL drive 1 and, on the next tick, go to IDLE.
REQ-029 o_Done SHALL pulse on the cycle of the IDLE transition; o_Busy SHALL clear on the same edge.
REQ-030 o_Ready SHALL rise the cycle after o_Done, giving no back-to-back acceptance in the Done cycle.
REQ-031 o_Tx SHALL be registered, changing only on i_Tick edges (and in SYNC/IDLE it is 1).
REQ-032 i_Tick asserted on the acceptance cycle SHALL NOT count; the first counted tick is the next one.
REQ-033 i_Valid while busy SHALL be ignored, with no capture and no error.
REQ-034 An illegal state encoding SHALL recover to IDLE on the next clock.

Reset
REQ-035 While i_Rst=1, regardless of clock:
- state=IDLE, bit counter=0
- o_Tx=1, o_Busy=0, o_Done=0, o_Ready=0
- o_Frame = all ones
REQ-036 On the first clock after i_Rst falls, o_Ready SHALL become 1.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately, with o_Tx=1 and no o_Done pulse.

Verification
REQ-038 DATA_W=8, LSB_FIRST=0, parity even, 1 stop, i_Data=8'hA5, tick every 4 clocks:
- required o_Tx sequence: 0, 1,0,1,0,0,1,0,1, 0, 1
- o_Frame = 12'b0_10100101_0_1_1
- o_Done pulses once, 11 ticks after the SYNC tick.
REQ-039 Odd parity, 2 stops, i_Data=8'h07, LSB_FIRST=1:
- required o_Tx sequence: 0, 1,1,1,0,0,0,0,0, 0, 1, 1
- frame length is 12 tick intervals.
REQ-040 DATA_W=7, parity none, 1 stop, i_Data=7'h41:
- no parity slot is sent; the frame is 9 tick intervals.
- o_Frame parity and stop2 positions read 1.
REQ-041 i_Valid held high continuously with a new value each cycle:
- exactly one word is captured per frame.
- o_Ready is low from acceptance through the o_Done cycle.
- the second frame carries the value present on the cycle o_Ready returned high.
REQ-042 i_Rst pulsed during DATA bit 3:
- o_Tx=1 and o_Busy=0 immediately (asynchronous).
- no o_Done pulse.
- o_Ready=1 one clock after release.
REQ-043 Mark and space modes with i_Data=8'h00 and 8'hFF:
- the parity slot is 1 (mark) and 0 (space) in all four cases.
- i_Parity=3'b111 behaves as none.
